// File: rtl/q_matrix_buffer_pkg.sv
// qr_pkg: constants and types shared by the QR datapath, controller and the
// Q matrix buffer.
//   DATA_WIDTH : Q8.8 word width
//   N          : matrix dimension
//   qmb_state_t: Q buffer FSM states (FILL, STREAM)
package qr_pkg;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned N          = 3;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } qmb_state_t;
endpackage

// File: rtl/q_matrix_buffer_if.sv
// q_matrix_buffer_if: groups the capture port (from the datapath) and the
// read-out handshake (to the result consumer) of q_matrix_buffer.
//   slave  : buffer side  (captures q columns, streams data_o)
//   master : environment side (datapath strobe + consumer)
interface q_matrix_buffer_if #(
  parameter int unsigned DATA_WIDTH = qr_pkg::DATA_WIDTH
);
  logic                  capture_i;
  logic [DATA_WIDTH-1:0] q1_i;
  logic [DATA_WIDTH-1:0] q2_i;
  logic [DATA_WIDTH-1:0] q3_i;
  logic                  start_read_i;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic [1:0]            row_o;
  logic [1:0]            col_o;
  logic                  full_o;
  logic                  done_o;
  logic                  overflow_o;

  modport slave (
    input  capture_i, q1_i, q2_i, q3_i, start_read_i, ready_i,
    output data_o, valid_o, row_o, col_o, full_o, done_o, overflow_o
  );

  modport master (
    output capture_i, q1_i, q2_i, q3_i, start_read_i, ready_i,
    input  data_o, valid_o, row_o, col_o, full_o, done_o, overflow_o
  );
endinterface

// File: rtl/q_col_mem.sv
// q_col_mem: N x N register file indexed [col][row]. One column-wide write
// port (all rows of one column per cycle) and one combinational element
// read port. Synchronous active-high reset clears every word.
//   i_we/i_wcol/i_wdata : column write
//   i_rcol/i_rrow       : read address
//   o_rdata             : element at [i_rcol][i_rrow]
module q_col_mem #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N          = 3,
  parameter int unsigned CW         = $clog2(N + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_we,
  input  logic [CW-1:0]                 i_wcol,
  input  logic [N-1:0][DATA_WIDTH-1:0]  i_wdata,
  input  logic [CW-1:0]                 i_rcol,
  input  logic [CW-1:0]                 i_rrow,
  output logic [DATA_WIDTH-1:0]         o_rdata
);
  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem <= '0;
    end else if (i_we) begin
      for (int unsigned r = 0; r < N; r++) begin
        r_mem[i_wcol][r] <= i_wdata[r];
      end
    end
  end

  assign o_rdata = r_mem[i_rcol][i_rrow];
endmodule

// File: rtl/q_matrix_buffer.sv
// q_matrix_buffer: collects N normalised q columns from the datapath, then
// streams the N x N Q matrix column-major over valid/ready.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : q_matrix_buffer_if slave (capture port, read handshake,
//                full/done/overflow status)
module q_matrix_buffer #(
  parameter int unsigned DATA_WIDTH = qr_pkg::DATA_WIDTH,
  parameter int unsigned N          = qr_pkg::N
) (
  input  logic              clk,
  input  logic              reset,
  q_matrix_buffer_if.slave  bus
);
  import qr_pkg::*;

  localparam int unsigned   CW    = $clog2(N + 1);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] LAST  = CW'(N - 1);
  localparam logic [CW-1:0] NFULL = CW'(N);

  qmb_state_t    r_state;
  logic [CW-1:0] r_wr_col;
  logic [CW-1:0] r_rd_row;
  logic [CW-1:0] r_rd_col;
  logic          r_valid;
  logic          r_done;
  logic          r_overflow;

  logic                         w_full;
  logic                         w_we;
  logic                         w_hs;
  logic [N-1:0][DATA_WIDTH-1:0] w_col_data;
  logic [DATA_WIDTH-1:0]        w_rdata;

  assign w_full = (r_wr_col == NFULL);
  // Captures land only while filling and not yet full; everything else is dropped.
  assign w_we   = bus.capture_i && (r_state == FILL) && !w_full;
  assign w_hs   = r_valid && bus.ready_i;

  // Rows beyond the three q inputs (only when N > 3) repeat q3.
  always_comb begin
    w_col_data = '0;
    for (int unsigned r = 0; r < N; r++) begin
      case (r)
        0:       w_col_data[r] = bus.q1_i;
        1:       w_col_data[r] = bus.q2_i;
        default: w_col_data[r] = bus.q3_i;
      endcase
    end
  end

  q_col_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N),
    .CW         (CW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_wcol  (r_wr_col),
    .i_wdata (w_col_data),
    .i_rcol  (r_rd_col),
    .i_rrow  (r_rd_row),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FILL;
      r_wr_col   <= '0;
      r_rd_row   <= '0;
      r_rd_col   <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_we) begin
            r_wr_col <= r_wr_col + ONE;
          end
          if (bus.capture_i && w_full) begin
            r_overflow <= 1'b1;
          end
          // Fullness is judged before this cycle's capture, so a capture
          // completing the matrix and a read in the same cycle ignores the read.
          if (bus.start_read_i && w_full) begin
            r_state  <= STREAM;
            r_valid  <= 1'b1;
            r_rd_row <= '0;
            r_rd_col <= '0;
          end
        end
        STREAM: begin
          if (bus.capture_i) begin
            r_overflow <= 1'b1;
          end
          if (w_hs) begin
            if (r_rd_row == LAST) begin
              r_rd_row <= '0;
              if (r_rd_col == LAST) begin
                r_rd_col <= '0;
                r_wr_col <= '0;
                r_valid  <= 1'b0;
                r_done   <= 1'b1;
                r_state  <= FILL;
              end else begin
                r_rd_col <= r_rd_col + ONE;
              end
            end else begin
              r_rd_row <= r_rd_row + ONE;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign bus.data_o     = w_rdata;
  assign bus.valid_o    = r_valid;
  assign bus.row_o      = 2'(r_rd_row);
  assign bus.col_o      = 2'(r_rd_col);
  assign bus.full_o     = w_full;
  assign bus.done_o     = r_done;
  assign bus.overflow_o = r_overflow;
endmodule

// File: doc/q_matrix_buffer.md
# q_matrix_buffer

Collects the normalised q vectors produced by the datapath's normalisation/multiply stage, one column per outer-loop iteration, until the full N×N Q matrix is held. It then streams Q out word by word over a valid/ready handshake to the result consumer (testbench or host interface). It sits directly downstream of the datapath's `q1out/q2out/q3out` outputs and is captured on the normalisation-done strobe.

## Interface
- `DATA_WIDTH`, default 16: word width, Q8.8 fixed point, stored unmodified.
- `N`, default 3: matrix dimension (rows per column and number of columns).
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `capture_i`: input, 1 bit. One-cycle strobe meaning the q inputs hold a valid column (driven by `done_norm_state`).
- `q1_i`, `q2_i`, `q3_i`: input, DATA_WIDTH each. Column elements for rows 0, 1 and 2.
- `start_read_i`: input, 1 bit. Request to begin streaming Q.
- `ready_i`: input, 1 bit. Consumer accepts `data_o` this cycle.
- `data_o`: output, DATA_WIDTH. Current Q element.
- `valid_o`: output, 1 bit. `data_o` is valid.
- `row_o`, `col_o`: output, 2 bits each. Indices of the current `data_o` element.
- `full_o`: output, 1 bit. All N columns are captured.
- `done_o`: output, 1 bit. One-cycle pulse after the last beat is accepted.
- `overflow_o`: output, 1 bit. Sticky flag: a capture was dropped.

## Operation
- **Storage:** N×N register array, indexed as mem[col][row]. `wr_col` counter runs 0..N. Read pointers are `rd_row` and `rd_col`.
- **FSM states:** FILL, STREAM.
- **FILL:**
  - When `capture_i` is high and `wr_col` < N: write `q1_i`, `q2_i`, `q3_i` into mem[`wr_col`][0..2], then `wr_col`++.
  - `full_o` = (`wr_col` == N).
  - `start_read_i` while `full_o` = 1: go to STREAM and clear `rd_row` and `rd_col`.
  - `start_read_i` while not full: ignored, no state change.
- **STREAM:**
  - `valid_o` = 1.
  - `data_o` = mem[`rd_col`][`rd_row`]; `row_o` = `rd_row`; `col_o` = `rd_col`.
  - Order is column-major.
  - On `valid_o & ready_i`: `rd_row`++. When `rd_row` == N-1, set `rd_row` = 0 and `rd_col`++.
  - On acceptance of the last beat (`rd_col` == N-1, `rd_row` == N-1):
    - pulse `done_o` on the next cycle;
    - clear `wr_col`, `rd_row` and `rd_col`;
    - return to FILL.
  - Memory contents are retained but are overwritten by subsequent captures.
- **Dropped captures:** `capture_i` while full in FILL, or at any time in STREAM, is dropped, memory is unchanged, and `overflow_o` is set. `overflow_o` clears only on `reset`.
- **Simultaneous events:**
  - `capture_i` and `start_read_i` in the same cycle with `wr_col` == N-1: the capture is accepted and the read is ignored, because the buffer was not yet full.
  - `capture_i` and `start_read_i` while full: the read is accepted and `overflow_o` is set.
- **Arithmetic:** no arithmetic on data; values pass through bit-exact. Counters do not wrap except via the explicit clear.

## Timing
- **Reset values:** state = FILL, `wr_col`/`rd_row`/`rd_col` = 0, all mem = 0, `valid_o` = 0, `data_o` = 0, `row_o`/`col_o` = 0, `full_o` = 0, `done_o` = 0, `overflow_o` = 0.
- **Reset mid-stream:** the next cycle equals the reset state. The partial stream is abandoned and no `done_o` pulse is issued.
- **Capture latency:** `capture_i` at edge t; the data is readable from t+1, and `full_o` rises at t+1 after the N-th capture.
- **Read latency:** `start_read_i` accepted at edge t; `valid_o` = 1 with element (0,0) from t+1.
- **Data outputs:** `data_o`, `row_o` and `col_o` are combinational from registered pointers and memory. They are stable while `valid_o & ~ready_i`.
- **Throughput:** N² beats take a minimum of N² cycles with `ready_i` held high.
- **Return to FILL:**
  - `valid_o` falls in the cycle after the last handshake, the same cycle `done_o` = 1.
  - `full_o` = 0 from that cycle.
  - A capture in that cycle is accepted into column 0.

## Structure
- Shared package `qr_pkg` holds the constants `DATA_WIDTH` and `N`, and the typedef `qmb_state_t` {FILL, STREAM}. The same package is usable by the datapath and controller.
- One natural sub-module: `q_col_mem`, the N×N register file with a column-wide write port and a single element read port.
- The FSM and pointers live in `q_matrix_buffer`.

## Test plan
- **Basic fill and stream:** capture columns {0x0100,0,0}, {0,0x0100,0}, {0,0,0x0100}, then `start_read_i` with `ready_i`=1 → `full_o` after the 3rd capture. Nine beats 0x0100,0,0,0,0x0100,0,0,0,0x0100 on consecutive cycles, `row_o`/`col_o` stepping 0..2, then a single `done_o` pulse.
- **Backpressure:** toggle `ready_i` 1,0,0,1 during the stream → `data_o`, `row_o` and `col_o` are held while `ready_i`=0. No beat is lost or duplicated; 9 handshakes in total.
- **Early read:** `start_read_i` after 2 captures → ignored, `valid_o` stays 0. After the 3rd capture, `start_read_i` starts the stream.
- **Overflow:** a 4th capture while full, and a capture during STREAM → memory unchanged, streamed values still those of the first 3 columns, `overflow_o`=1 until `reset`.
- **Reset mid-stream:** `reset` after the 4th beat → all outputs are 0 next cycle and there is no `done_o`. A new fill of 3 columns followed by a read streams the new values.
- **Back-to-back:** capture in the same cycle as `done_o` → stored as column 0 of the next matrix, and the second read returns it first.
